// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multi-cycle sequencer.
// Contents:
//   - ALU op codes from the decoder. The M ops are the ones muldiv_seq accepts.
//   - The sequencer state encoding and the iteration counter width.
//   - The internal op encoding latched at accept.
//   - Helpers that classify and decode a decoder op code.
package muldiv_seq_pkg;

    localparam int unsigned AluOpW = 6;
    localparam int unsigned MdCntW = 5;

    // Decoder ALU op codes (subset relevant to this block)
    localparam logic [AluOpW-1:0] OpAluNop  = 6'd0;
    localparam logic [AluOpW-1:0] OpAluAdd  = 6'd1;
    localparam logic [AluOpW-1:0] OpAluSub  = 6'd2;
    localparam logic [AluOpW-1:0] OpAluMul  = 6'd20;
    localparam logic [AluOpW-1:0] OpAluMulh = 6'd21;
    localparam logic [AluOpW-1:0] OpAluDiv  = 6'd22;
    localparam logic [AluOpW-1:0] OpAluDivu = 6'd23;
    localparam logic [AluOpW-1:0] OpAluRem  = 6'd24;
    localparam logic [AluOpW-1:0] OpAluRemu = 6'd25;

    typedef enum logic [1:0] {
        MdIdle = 2'd0,
        MdCalc = 2'd1,
        MdFix  = 2'd2,
        MdDone = 2'd3
    } md_state_e;

    typedef enum logic [2:0] {
        MdOpMul  = 3'd0,
        MdOpMulh = 3'd1,
        MdOpDiv  = 3'd2,
        MdOpDivu = 3'd3,
        MdOpRem  = 3'd4,
        MdOpRemu = 3'd5
    } md_op_e;

    function automatic logic is_m_op(input logic [AluOpW-1:0] op);
        return (op == OpAluMul)  || (op == OpAluMulh) || (op == OpAluDiv) ||
               (op == OpAluDivu) || (op == OpAluRem)  || (op == OpAluRemu);
    endfunction

    // Only meaningful when is_m_op() is true
    function automatic md_op_e decode_op(input logic [AluOpW-1:0] op);
        case (op)
            OpAluMulh: return MdOpMulh;
            OpAluDiv:  return MdOpDiv;
            OpAluDivu: return MdOpDivu;
            OpAluRem:  return MdOpRem;
            OpAluRemu: return MdOpRemu;
            default:   return MdOpMul;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One iteration step of the shared multiply / divide datapath (pure combinational).
// Ports:
//   is_div_i  1       1: restoring-divide step, 0: shift-add multiply step
//   acc_i     2*Xlen  current accumulator
//                     multiply: {partial product high, remaining multiplier}
//                     divide:   {partial remainder, dividend/quotient}
//   opnd_i    Xlen    multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_o     2*Xlen  accumulator after one step
module muldiv_iter #(
    parameter int unsigned Xlen = 32
) (
    input  logic              is_div_i,
    input  logic [2*Xlen-1:0] acc_i,
    input  logic [Xlen-1:0]   opnd_i,
    output logic [2*Xlen-1:0] acc_o
);

    logic [Xlen:0] mul_sum;
    logic [Xlen:0] div_trial;
    logic [Xlen:0] div_diff;

    always_comb begin
        // Multiply: add multiplicand into the high half when the LSB of the
        // remaining multiplier is set, then shift right keeping the carry.
        mul_sum   = {1'b0, acc_i[2*Xlen-1:Xlen]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        // Divide: shifted partial remainder is one bit wider than the divisor.
        // Since remainder < divisor, a set MSB of the difference means borrow.
        div_trial = acc_i[2*Xlen-1:Xlen-1];
        div_diff  = div_trial - {1'b0, opnd_i};

        if (is_div_i) begin
            if (!div_diff[Xlen]) begin
                acc_o = {div_diff[Xlen-1:0], acc_i[Xlen-2:0], 1'b1};
            end else begin
                acc_o = {div_trial[Xlen-1:0], acc_i[Xlen-2:0], 1'b0};
            end
        end else begin
            acc_o = {mul_sum, acc_i[Xlen-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer (MUL, MULH, DIV, DIVU, REM, REMU) beside the execute ALU.
// Operands are reduced to unsigned magnitudes at accept. 32 shift-add or restoring
// steps follow, then a fix-up cycle applies the sign and selects the result word.
// Divide-by-zero and signed overflow complete straight from IDLE.
// Ports:
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_valid   execute stage presents an op
//   i_alu_op  decoder op code
//   i_rs1     operand A (multiplicand / dividend)
//   i_rs2     operand B (multiplier / divisor)
//   i_flush   kill in-flight op
//   o_stall   hold pipeline (combinational)
//   o_busy    state is not IDLE
//   o_done    one-cycle result-valid pulse
//   o_result  registered result, held until next completion
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int unsigned Xlen = 32,
    parameter int unsigned OpW  = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic [OpW-1:0]  i_alu_op,
    input  logic [Xlen-1:0] i_rs1,
    input  logic [Xlen-1:0] i_rs2,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic [Xlen-1:0] o_result
);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic              neg_q, neg_d;
    logic [MdCntW-1:0] cnt_q, cnt_d;
    logic [2*Xlen-1:0] acc_q, acc_d;
    logic [Xlen-1:0]   opnd_q, opnd_d;
    logic [Xlen-1:0]   result_q, result_d;

    // Accept-side decode
    md_op_e            op_dec;
    logic              accept;
    logic              signed_op, div_op, rem_op;
    logic              sign_a, sign_b;
    logic [Xlen-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, fast_path;
    logic [Xlen-1:0]   fast_res;

    // Iteration / fix-up
    logic              iter_is_div;
    logic [2*Xlen-1:0] acc_step;
    logic [2*Xlen-1:0] acc_neg;
    logic [Xlen-1:0]   quot, rem;
    logic [Xlen-1:0]   fix_res;

    // ------------------------------------------------------------------
    // Accept decode
    // ------------------------------------------------------------------
    always_comb begin
        op_dec    = decode_op(i_alu_op);
        accept    = (state_q == MdIdle) && i_valid && is_m_op(i_alu_op) && !i_flush;

        signed_op = (op_dec == MdOpMulh) || (op_dec == MdOpDiv) || (op_dec == MdOpRem);
        div_op    = (op_dec == MdOpDiv) || (op_dec == MdOpDivu) ||
                    (op_dec == MdOpRem) || (op_dec == MdOpRemu);
        rem_op    = (op_dec == MdOpRem) || (op_dec == MdOpRemu);

        // MUL stays unsigned: the low product word does not depend on signedness
        sign_a    = signed_op && i_rs1[Xlen-1];
        sign_b    = signed_op && i_rs2[Xlen-1];
        // |0x80000000| wraps to itself, which is the correct unsigned magnitude
        mag_a     = sign_a ? -i_rs1 : i_rs1;
        mag_b     = sign_b ? -i_rs2 : i_rs2;

        div_zero  = div_op && (i_rs2 == '0);
        div_ovf   = ((op_dec == MdOpDiv) || (op_dec == MdOpRem)) &&
                    (i_rs1 == {1'b1, {(Xlen-1){1'b0}}}) && (i_rs2 == '1);
        fast_path = div_zero || div_ovf;

        if (div_zero) begin
            fast_res = rem_op ? i_rs1 : '1;
        end else begin
            fast_res = rem_op ? '0 : {1'b1, {(Xlen-1){1'b0}}};
        end
    end

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    assign iter_is_div = (op_q != MdOpMul) && (op_q != MdOpMulh);

    muldiv_iter #(
        .Xlen (Xlen)
    ) u_iter (
        .is_div_i (iter_is_div),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    // Sign correction and field select
    always_comb begin
        acc_neg = -acc_q;
        quot    = acc_q[Xlen-1:0];
        rem     = acc_q[2*Xlen-1:Xlen];
        case (op_q)
            MdOpMul:  fix_res = acc_q[Xlen-1:0];
            MdOpMulh: fix_res = neg_q ? acc_neg[2*Xlen-1:Xlen] : acc_q[2*Xlen-1:Xlen];
            MdOpDiv:  fix_res = neg_q ? -quot : quot;
            MdOpRem:  fix_res = neg_q ? -rem : rem;
            MdOpRemu: fix_res = rem;
            default:  fix_res = quot;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= MdIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            MdIdle: begin
                if (accept) begin
                    state_d = fast_path ? MdDone : MdCalc;
                end
            end
            MdCalc: begin
                if (cnt_q == '1) begin
                    state_d = MdFix;
                end
            end
            MdFix:   state_d = MdDone;
            MdDone:  state_d = MdIdle;
            default: state_d = MdIdle;
        endcase
        if (i_flush) begin
            state_d = MdIdle;
        end
    end

    // FSM: outputs
    always_comb begin
        o_stall  = accept || (state_q == MdCalc) || (state_q == MdFix);
        o_busy   = (state_q != MdIdle);
        o_done   = (state_q == MdDone);
        o_result = result_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            MdIdle: begin
                if (accept) begin
                    if (fast_path) begin
                        result_d = fast_res;
                    end else begin
                        op_d  = op_dec;
                        cnt_d = '0;
                        case (op_dec)
                            MdOpMulh, MdOpDiv: neg_d = sign_a ^ sign_b;
                            MdOpRem:           neg_d = sign_a;
                            default:           neg_d = 1'b0;
                        endcase
                        if (div_op) begin
                            acc_d  = {{Xlen{1'b0}}, mag_a};
                            opnd_d = mag_b;
                        end else begin
                            acc_d  = {{Xlen{1'b0}}, mag_b};
                            opnd_d = mag_a;
                        end
                    end
                end
            end
            MdCalc: begin
                if (!i_flush) begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MdFix: begin
                // A flush here must leave the previous result visible
                if (!i_flush) begin
                    result_d = fix_res;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            op_q     <= MdOpMul;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq. Expected results come from a plain-arithmetic model and
// are queued at issue. A monitor pops the queue and compares on every o_done.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic [5:0]  i_alu_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_stall;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    muldiv_seq u_dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_alu_op (i_alu_op),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_flush  (i_flush),
        .o_stall  (o_stall),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, want finish before 1000000");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Behavioural reference: RISC-V M semantics on 64-bit integers
    function automatic logic [31:0] ref_model(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 0;
        case (op)
            OpAluMul:  p = ua * ub;
            OpAluMulh: p = (sa * sb) >>> 32;
            OpAluDiv:  p = (b == 0) ? -1 : sa / sb;
            OpAluDivu: p = (b == 0) ? -1 : ua / ub;
            OpAluRem:  p = (b == 0) ? sa : sa % sb;
            OpAluRemu: p = (b == 0) ? ua : ua % ub;
            default:   p = 0;
        endcase
        return p[31:0];
    endfunction

    function automatic bit is_fast(input logic [5:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        bit divish;
        bit sdiv;
        divish = (op == OpAluDiv) || (op == OpAluDivu) || (op == OpAluRem) || (op == OpAluRemu);
        sdiv   = (op == OpAluDiv) || (op == OpAluRem);
        return divish && ((b == 0) || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Scoreboard monitor
    always @(negedge i_clk) begin
        if (i_rst_n && o_done) begin
            check("done_has_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("result", o_result, exp_q.pop_front());
            end
        end
    end

    // Issue one M op and follow it to completion with timing checks
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        bit fast;
        bit stall_held;
        int lat;
        fast = is_fast(op, a, b);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_alu_op = op;
        i_rs1    = a;
        i_rs2    = b;
        #1;
        check("stall_at_accept", 32'(o_stall), 32'd1);
        exp_q.push_back(ref_model(op, a, b));
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rs1   = $urandom;
        i_rs2   = $urandom;
        lat = 1;
        stall_held = 1'b1;
        while (!o_done && lat < 60) begin
            if (!o_stall) stall_held = 1'b0;
            @(negedge i_clk);
            lat++;
        end
        check("done_latency", 32'(lat), fast ? 32'd1 : 32'd34);
        check("stall_held", 32'(stall_held), 32'd1);
        check("stall_low_in_done", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        #1;
        check("busy_after_done", 32'(o_busy), 32'd0);
        check("done_single_cycle", 32'(o_done), 32'd0);
    endtask

    // Kill an in-flight DIVU after at_cycle CALC cycles, by flush or by reset
    task automatic kill_mid(input bit use_rst, input int at_cycle);
        logic [31:0] prev;
        prev = o_result;
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_alu_op = OpAluDivu;
        i_rs1    = $urandom;
        i_rs2    = $urandom | 32'd1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (at_cycle - 1) @(negedge i_clk);
        check("busy_before_kill", 32'(o_busy), 32'd1);
        if (use_rst) i_rst_n = 1'b0;
        else         i_flush = 1'b1;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_flush = 1'b0;
        #1;
        check(use_rst ? "rst_busy" : "flush_busy", 32'(o_busy), 32'd0);
        check(use_rst ? "rst_stall" : "flush_stall", 32'(o_stall), 32'd0);
        check(use_rst ? "rst_done" : "flush_done", 32'(o_done), 32'd0);
        check(use_rst ? "rst_result" : "flush_result", o_result, use_rst ? 32'd0 : prev);
        repeat (40) @(negedge i_clk);
        check("no_late_done_pending", 32'(exp_q.size()), 32'd0);
        run_op(OpAluDivu, 32'd100, 32'd7);
    endtask

    // Present a non-accepted request for one cycle
    task automatic try_reject(input logic [5:0] op, input logic flush);
        @(negedge i_clk);
        i_valid  = 1'b1;
        i_alu_op = op;
        i_rs1    = $urandom;
        i_rs2    = $urandom;
        i_flush  = flush;
        #1;
        check("reject_stall", 32'(o_stall), 32'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        #1;
        check("reject_busy", 32'(o_busy), 32'd0);
        check("reject_done", 32'(o_done), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [4];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h0000_0001;
        if ($urandom_range(3) == 0) return specials[$urandom_range(3)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0] ops [6];
        ops[0] = OpAluMul;
        ops[1] = OpAluMulh;
        ops[2] = OpAluDiv;
        ops[3] = OpAluDivu;
        ops[4] = OpAluRem;
        ops[5] = OpAluRemu;

        i_rst_n  = 1'b0;
        i_valid  = 1'b0;
        i_alu_op = OpAluNop;
        i_rs1    = '0;
        i_rs2    = '0;
        i_flush  = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        check("reset_result", o_result, 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_stall", 32'(o_stall), 32'd0);
        i_rst_n = 1'b1;

        // Directed cases
        run_op(OpAluMul,  32'd7,          32'hFFFF_FFFD);
        run_op(OpAluMulh, 32'h8000_0000,  32'h8000_0000);
        run_op(OpAluMulh, 32'hFFFF_FFFF,  32'd2);
        run_op(OpAluDiv,  32'hFFFF_FFF9,  32'd2);
        run_op(OpAluRem,  32'hFFFF_FFF9,  32'd2);
        run_op(OpAluDivu, 32'hFFFF_FFF9,  32'd2);
        run_op(OpAluRemu, 32'hFFFF_FFF9,  32'd2);
        run_op(OpAluDiv,  32'd5,          32'd0);
        run_op(OpAluRemu, 32'd5,          32'd0);
        run_op(OpAluDiv,  32'h8000_0000,  32'hFFFF_FFFF);
        run_op(OpAluRem,  32'h8000_0000,  32'hFFFF_FFFF);

        kill_mid(1'b0, 10);
        kill_mid(1'b1, 5);

        try_reject(OpAluAdd, 1'b0);
        try_reject(OpAluNop, 1'b0);
        try_reject(OpAluMul, 1'b1);

        // Randomized ops
        for (int i = 0; i < 60; i++) begin
            run_op(ops[$urandom_range(5)], pick_operand(), pick_operand());
        end

        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M operations the decoder emits: MUL, MULH, DIV, DIVU, REM, REMU.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation, stalls the pipeline while it iterates (32-step shift-add multiply or restoring divide), then returns a registered result with a one-cycle done pulse.
- Divide-by-zero and signed overflow finish on a 1-cycle fast path.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- OP_W, 6, width of the ALU op code; matches the decoder's o_alu_op.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  execute stage presents an operation this cycle.
- i_alu_op  input  OP_W  op code; only `OP_ALU_MUL/MULH/DIV/DIVU/REM/REMU are accepted.
- i_rs1  input  XLEN  operand A (multiplicand / dividend).
- i_rs2  input  XLEN  operand B (multiplier / divisor).
- i_flush  input  1  kill the in-flight operation (branch taken / trap).
- o_stall  output  1  hold the pipeline; combinational.
- o_busy  output  1  state != IDLE; registered-state decode.
- o_done  output  1  result valid this cycle; one-cycle pulse.
- o_result  output  XLEN  result; registered, holds until next completion.

Behaviour:
- Reset (i_rst_n=0 at an edge): state=IDLE, counter=0, internal regs=0, o_result=0, o_done=0, o_busy=0. o_stall=0 unless i_valid with an M op is presented in IDLE.
- Accept: accept = IDLE & i_valid & is_m_op & !i_flush. Non-M ops with i_valid are ignored, and o_stall stays 0.
- o_stall = accept | (state==CALC) | (state==FIX). It is low in DONE, so the pipeline advances while the result is consumed.
- States: IDLE, CALC, FIX, DONE.
- IDLE to DONE on accept, fast path:
  - DIV/DIVU/REM/REMU with rs2==0: quotient = 0xFFFFFFFF; remainder = rs1.
  - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient = 0x80000000; remainder = 0.
- IDLE to CALC on any other accept:
  - Latch op, operand signs and magnitudes (signed ops take |x|; MUL treated unsigned because low product bits are sign-independent).
  - Counter=0.
- CALC: one iteration per edge. Multiply: 64-bit shift-add. Divide: restoring subtract-shift on a 64-bit {rem,quot} register. After the 32nd iteration (counter==31), go to FIX.
- FIX, one edge: apply sign correction and select the field, then go to DONE.
  - MULH: negate the 64-bit product if signs differ; take the high word.
  - MUL: low word.
  - DIV: negate the quotient if sign(rs1)^sign(rs2).
  - REM: negate the remainder if sign(rs1).
  - DIVU/REMU: no correction.
- DONE: o_done=1 for exactly one cycle, then IDLE. No acceptance in DONE; the next op is accepted at the earliest in the following IDLE cycle.
- Latency (edge of accept = edge 0): normal ops give o_done in the cycle after edge 33. Fast-path ops give o_done in the cycle after edge 0.
- Flush: i_flush=1 in any state goes to IDLE at the next edge. No o_done, o_result unchanged. Flush beats accept when coincident. A flush in DONE still lets the current o_done cycle stand.
- Reset mid-operation behaves like flush and also clears o_result.
- Arithmetic: magnitude of 0x80000000 is 0x80000000 as an unsigned 32-bit value. Negation is two's complement at the field width; no saturation.

Decomposition:
- definitions.vh: state encodings MD_IDLE/MD_CALC/MD_FIX/MD_DONE (2 bits), MD_CNT_W=5, and the existing `OP_ALU_MUL..`OP_ALU_REMU codes, which are reused and not redefined.
- One combinational sub-module, muldiv_iter: given mode (mul/div), the 64-bit accumulator and the 32-bit operand, produce the next accumulator for one step.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD:
  - o_stall high at accept and for 33 following cycles.
  - o_done in the cycle after edge 33 with 0xFFFFFFEB.
  - o_busy falls the cycle after.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MULH 0xFFFFFFFF × 2 gives 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9, rs2=2 gives 0xFFFFFFFD. REM same operands gives 0xFFFFFFFF. DIVU same operands gives 0x7FFFFFFC. REMU same operands gives 1.
- Fast path, each with o_done one cycle after accept and no CALC cycles:
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM with the same operands gives 0.
- Flush / reset mid-operation:
  - i_flush on CALC cycle 10 gives state IDLE next edge, o_stall low, no o_done, o_result unchanged.
  - A following DIVU 100/7 then gives 14 at normal latency.
  - Repeat with i_rst_n=0 on CALC cycle 5; o_result becomes 0.
- i_valid with `OP_ALU_ADD, and with `OP_ALU_NOP, gives o_stall=0, o_busy=0, no o_done.
- i_valid with MUL coincident with i_flush is not accepted.
